microwave_cook_controller: RTL

//  Sequencing FSM for the microwave timer datapath. Takes validated key digits from the keypad encoder and
//  the 1 Hz tick from the divider, and holds a 4-digit BCD MM:SS time. It decides when the magnetron runs,

---
 rtl/mwave_pkg.sv | 51 +++++
 rtl/bcd_mmss_down.sv | 51 +++++
 rtl/microwave_cook_controller.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mwave_pkg.sv
// Shared types, widths and BCD helpers for the microwave cook controller.
package mwave_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned STATE_W = 3;

  localparam logic [BCD_W-1:0] BCD_MAX_DIGIT    = BCD_W'(9);
  localparam logic [BCD_W-1:0] BCD_MAX_SEC_TENS = BCD_W'(5);

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = STATE_W'(0),
    ST_SET   = STATE_W'(1),
    ST_COOK  = STATE_W'(2),
    ST_PAUSE = STATE_W'(3),
    ST_DONE  = STATE_W'(4)
  } state_e;

  typedef struct packed {
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
  } mmss_t;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] d);
    return d <= BCD_MAX_DIGIT;
  endfunction

  // One-second BCD decrement; out-of-range seconds tens count down naturally, 00:00 holds.
  function automatic mmss_t mmss_dec(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.sec_ones != '0) begin
      r.sec_ones = t.sec_ones - BCD_W'(1);
    end else if (t.sec_tens != '0) begin
      r.sec_tens = t.sec_tens - BCD_W'(1);
      r.sec_ones = BCD_MAX_DIGIT;
    end else if ((t.min_ones != '0) || (t.min_tens != '0)) begin
      r.sec_tens = BCD_MAX_SEC_TENS;
      r.sec_ones = BCD_MAX_DIGIT;
      if (t.min_ones != '0) begin
        r.min_ones = t.min_ones - BCD_W'(1);
      end else begin
        r.min_tens = t.min_tens - BCD_W'(1);
        r.min_ones = BCD_MAX_DIGIT;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mmss_down.sv
// Four-digit BCD MM:SS register with shift-in entry, clear and one-second decrement.
module bcd_mmss_down
  import mwave_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_en,
  input  logic             load_shift,
  input  logic [BCD_W-1:0] shift_digit,
  input  logic             clear,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             is_zero
);

  mmss_t time_q;
  mmss_t time_d;

  // Next time value: clear beats key entry beats countdown.
  always_comb begin
    time_d = time_q;
    if (clear) begin
      time_d = '0;
    end else if (load_shift) begin
      time_d.min_tens = time_q.min_ones;
      time_d.min_ones = time_q.sec_tens;
      time_d.sec_tens = time_q.sec_ones;
      time_d.sec_ones = shift_digit;
    end else if (dec_en) begin
      time_d = mmss_dec(time_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_q  <= '0;
      is_zero <= 1'b1;
    end else begin
      time_q  <= time_d;
      is_zero <= (time_d == '0);
    end
  end

  assign min_tens = time_q.min_tens;
  assign min_ones = time_q.min_ones;
  assign sec_tens = time_q.sec_tens;
  assign sec_ones = time_q.sec_ones;

endmodule

// File: rtl/microwave_cook_controller.sv
// Cook sequencing FSM over a BCD MM:SS countdown; DONE_BEEP_EN adds a beep output
// and a timed auto-return from DONE after BEEP_SECS ticks.
module microwave_cook_controller
  import mwave_pkg::*;
`ifdef DONE_BEEP_EN
#(
  parameter int unsigned BEEP_SECS = 3
)
`endif
(
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1hz,
  input  logic [BCD_W-1:0]   digit,
  input  logic               digit_valid,
  input  logic               start,
  input  logic               stop_clear,
  input  logic               door_closed,
  output logic               mag_on,
  output logic               done,
  output logic [STATE_W-1:0] state,
  output logic [BCD_W-1:0]   min_tens,
  output logic [BCD_W-1:0]   min_ones,
  output logic [BCD_W-1:0]   sec_tens,
  output logic [BCD_W-1:0]   sec_ones
`ifdef DONE_BEEP_EN
  ,
  output logic               beep
`endif
);

  state_e state_q;
  state_e state_d;

  logic dec_en;
  logic load_shift;
  logic clear;
  logic is_zero;
  logic door_open;
  logic digit_ok;
  logic at_one;

`ifdef DONE_BEEP_EN
  localparam int unsigned CNT_W = $clog2(BEEP_SECS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEEP_SECS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
`endif

  bcd_mmss_down u_time (
    .clk         (clk),
    .rst         (rst),
    .dec_en      (dec_en),
    .load_shift  (load_shift),
    .shift_digit (digit),
    .clear       (clear),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .is_zero     (is_zero)
  );

  assign door_open = !door_closed;
  assign digit_ok  = digit_valid && bcd_valid(digit);
  assign at_one    = (min_tens == '0) && (min_ones == '0) &&
                     (sec_tens == '0) && (sec_ones == BCD_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath strobes; each branch chain follows the
  // door > stop_clear > start > tick > digit priority.
  always_comb begin
    state_d    = state_q;
    dec_en     = 1'b0;
    load_shift = 1'b0;
    clear      = 1'b0;
`ifdef DONE_BEEP_EN
    cnt_d      = '0;
`endif
    case (state_q)
      ST_IDLE, ST_SET: begin
        if (stop_clear) begin
          state_d = ST_IDLE;
          clear   = 1'b1;
        end else if (start) begin
          if ((state_q == ST_SET) && door_closed && !is_zero) begin
            state_d = ST_COOK;
          end
        end else if (tick_1hz) begin
          state_d = state_q;
        end else if (digit_ok) begin
          load_shift = 1'b1;
          state_d    = ST_SET;
        end
      end
      ST_COOK: begin
        if (door_open || stop_clear) begin
          state_d = ST_PAUSE;
        end else if (start) begin
          state_d = ST_COOK;
        end else if (tick_1hz) begin
          dec_en = 1'b1;
          if (at_one) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_PAUSE: begin
        if (stop_clear) begin
          state_d = ST_IDLE;
          clear   = 1'b1;
        end else if (start && door_closed) begin
          state_d = ST_COOK;
        end
      end
      ST_DONE: begin
        if (door_open || stop_clear) begin
          state_d = ST_IDLE;
        end
`ifdef DONE_BEEP_EN
        else begin
          cnt_d = cnt_q;
          if (!start && tick_1hz) begin
            if (cnt_q == CNT_LAST) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        clear   = 1'b1;
      end
    endcase
  end

  // Registered outputs follow the next state so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_on <= 1'b0;
      done   <= 1'b0;
    end else begin
      mag_on <= (state_d == ST_COOK);
      done   <= (state_d == ST_DONE);
    end
  end

`ifdef DONE_BEEP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      beep  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      beep  <= (state_d == ST_DONE);
    end
  end
`endif

  assign state = state_q;

endmodule
